// File: rtl/ftdi_tx_if.sv
// Word-side handshake between an internal word producer and ftdi_tx.
//   word_in    : 20-bit payload word
//   sof_in     : word is the first of a frame
//   word_valid : word_in/sof_in are valid (producer -> ftdi_tx)
//   word_ready : ftdi_tx can accept a word this cycle (ftdi_tx -> producer)
// Modports: master = word producer, slave = ftdi_tx.
interface ftdi_tx_if;
  localparam int unsigned WORD_W = 20;

  logic [WORD_W-1:0] word_in;
  logic              sof_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, sof_in, word_valid, input word_ready);
  modport slave  (input word_in, sof_in, word_valid, output word_ready);
endinterface

// File: rtl/ftdi_tx.sv
// Host-bound transmitter for the FT245-style synchronous FIFO bus.
// Buffers 20-bit words (with start-of-frame flag) in a word FIFO and sends each
// as three bytes: {S,W[19:13]}, {0,W[12:6]}, {00,W[5:0]}. The bus is released
// to the receive path (rxf_n low) only at word boundaries.
// Ports:
//   clk_60, rst  : 60 MHz FTDI clock, synchronous active-high reset
//   wr           : word handshake (ftdi_tx_if.slave)
//   txe_n        : low = FTDI TX FIFO has space (byte accepted on that edge)
//   rxf_n        : low = host data pending, receive path has priority
//   data_out     : byte on the FTDI bus (combinational from FIFO head / byte index)
//   data_oe      : enable for the top-level bus tristate drivers
//   wr_n         : write strobe, active low
//   siwu_n       : send-immediate strobe, active low
//   fifo_level   : words buffered
//   busy         : block owns the bus
// Optional feature: define FTDI_TX_SIWU_EN to pulse siwu_n after FLUSH_IDLE idle
// cycles following the last word; otherwise siwu_n is tied high.
module ftdi_tx #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FLUSH_IDLE = 32
) (
  input  logic                          clk_60,
  input  logic                          rst,
  ftdi_tx_if.slave                      wr,
  input  logic                          txe_n,
  input  logic                          rxf_n,
  output logic [7:0]                    data_out,
  output logic                          data_oe,
  output logic                          wr_n,
  output logic                          siwu_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 21;

  // Parameter sanity: depth must be a power of two >= 2, flush delay nonzero.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FLUSH_IDLE == 0) begin : g_param_chk
    $error("ftdi_tx: illegal FIFO_DEPTH or FLUSH_IDLE");
  end

  typedef enum logic [1:0] {IDLE, TURN, WRITE} state_t;

  state_t         state, state_nx;
  logic [1:0]     idx, idx_nx;
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [EW-1:0]  head;
  logic           push, pop;
  logic           last_word;
  logic [LW-1:0]  level_nx;

  assign push      = wr.word_valid & wr.word_ready;
  assign head      = mem[rd_ptr];
  // FIFO is empty after popping the head unless a word arrives on the same edge.
  assign last_word = (fifo_level == LW'(1)) && !push;
  assign level_nx  = fifo_level + LW'(push) - LW'(pop);

  // Word storage, no reset needed: validity is tracked by the pointers.
  always_ff @(posedge clk_60) begin
    if (push) mem[wr_ptr] <= {wr.sof_in, wr.word_in};
  end

  // Next-state, byte index and pop decision.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0 && rxf_n && !txe_n) state_nx = TURN;
      end
      TURN: begin
        state_nx = WRITE;
      end
      WRITE: begin
        if (!txe_n) begin
          if (idx == 2'd2) begin
            idx_nx = 2'd0;
            pop    = 1'b1;
            if (last_word || !rxf_n) state_nx = IDLE;
          end else begin
            idx_nx = idx + 2'd1;
          end
        end else if (idx == 2'd0 && !rxf_n) begin
          // Stalled on a word boundary: hand the bus to the receive path.
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Byte select from the FIFO head; zero while the bus is not ours.
  always_comb begin
    data_out = 8'h00;
    if (state != IDLE) begin
      case (idx)
        2'd0:    data_out = {head[20], head[19:13]};
        2'd1:    data_out = {1'b0, head[12:6]};
        default: data_out = {2'b00, head[5:0]};
      endcase
    end
  end

  // State, FIFO pointers and registered bus/handshake outputs.
  always_ff @(posedge clk_60) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      wr.word_ready <= 1'b1;
      wr_n          <= 1'b1;
      data_oe       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level    <= level_nx;
      wr.word_ready <= (level_nx != LW'(FIFO_DEPTH));
      wr_n          <= (state_nx != WRITE);
      data_oe       <= (state_nx != IDLE);
      busy          <= (state_nx != IDLE);
    end
  end

`ifdef FTDI_TX_SIWU_EN
  localparam int unsigned CW = $clog2(FLUSH_IDLE + 1);

  logic          armed;
  logic [CW-1:0] idle_cnt;

  // Idle flush timer: armed by the pop that empties the FIFO, one siwu_n pulse.
  always_ff @(posedge clk_60) begin
    if (rst) begin
      armed    <= 1'b0;
      idle_cnt <= '0;
      siwu_n   <= 1'b1;
    end else begin
      siwu_n <= 1'b1;
      if (push) begin
        armed    <= 1'b0;
        idle_cnt <= '0;
      end else if (pop && last_word) begin
        armed    <= 1'b1;
        idle_cnt <= '0;
      end else if (armed && state == IDLE) begin
        if (idle_cnt == CW'(FLUSH_IDLE - 1)) begin
          siwu_n   <= 1'b0;
          armed    <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + CW'(1);
        end
      end
    end
  end
`else
  assign siwu_n = 1'b1;
`endif

endmodule

// File: doc/ftdi_tx.md
Name: ftdi_tx

Overview:
- Host-bound transmitter for the FT245-style synchronous FIFO interface; the write-side counterpart of the FTDI byte receiver.
- Accepts 20-bit words, each with a start-of-frame flag, from internal logic (readback or status source) and buffers them in a word FIFO.
- Serialises each word into the same 3-byte, bit-7-sync format the receiver consumes.
- Drives wr_n and the shared data bus; yields the bus to the receive path at word boundaries.

Parameters:
- FIFO_DEPTH, 16, word FIFO depth (power of two, >= 2).
- FLUSH_IDLE, 32, idle cycles after the last byte before a send-immediate pulse (used only with the optional feature).

Ports:
- clk_60  in  1  FTDI 60 MHz clock.
- rst  in  1  synchronous, active-high reset.
- word_in  in  20  payload word.
- sof_in  in  1  word is the first of a frame.
- word_valid  in  1  word_in/sof_in are valid.
- word_ready  out  1  FIFO can accept a word.
- txe_n  in  1  low = FTDI TX FIFO has space.
- rxf_n  in  1  low = host data pending; receive path has priority.
- data_out  out  8  byte driven onto the FTDI bus.
- data_oe  out  1  top level enables bus tristate drivers.
- wr_n  out  1  write strobe, active low.
- siwu_n  out  1  send-immediate strobe, active low.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words buffered.
- busy  out  1  block owns the bus (state != IDLE).

Behaviour:
- Reset values: state=IDLE, FIFO empty, byte index=0. Outputs: wr_n=1, data_oe=0, siwu_n=1, word_ready=1, fifo_level=0, busy=0, data_out=0.
- FIFO push: word_valid & word_ready. word_ready = !full, registered from level.
  - Push and pop in the same cycle while full: the pop frees the slot next cycle; word_ready stays 0 that cycle.
  - Push while full is impossible by handshake.
- Encoding, word W with flag S:
  - byte0 = {S, W[19:13]}
  - byte1 = {1'b0, W[12:6]}
  - byte2 = {2'b00, W[5:0]}
  - Bytes go out in order byte0, byte1, byte2.
- States: IDLE, TURN, WRITE. Outputs decode from the registered state:
  - wr_n = !(WRITE)
  - data_oe = (TURN|WRITE)
- IDLE -> TURN: FIFO non-empty & rxf_n=1 & txe_n=0. Otherwise remain in IDLE.
- TURN: one bus-turnaround cycle; data_out=byte0, wr_n=1. Always -> WRITE.
- WRITE, accept = !txe_n (byte transferred on this edge):
  - accept & idx<2: idx+1.
  - accept & idx==2: idx=0 and pop the word. Next state is IDLE if the FIFO is empty after the pop or rxf_n=0; otherwise stay in WRITE with the next word's byte0.
  - !accept: hold data_out and idx; wr_n stays 0, which the FTDI ignores while txe_n=1. If idx==0 and rxf_n=0, go to IDLE.
- Never abandon a word mid-byte-sequence. An rxf_n assertion at idx 1/2 waits for word completion.
- data_out is combinational from FIFO head and idx; it is stable for any cycle wr_n=0.
- Latency: word pushed into an empty FIFO on an idle bus produces first byte accepted 3 cycles later (push, IDLE->TURN, TURN->WRITE); minimum 3 cycles per word after that.
- Reset mid-word: the partial word is discarded, FIFO is cleared, and the bus is released the next cycle.

Optional Feature:
- Macro FTDI_TX_SIWU_EN.
- Defined: an idle counter starts after a word is popped and the state returns to IDLE with the FIFO empty.
  - After FLUSH_IDLE consecutive IDLE cycles with no push, siwu_n=0 for exactly one cycle, then the counter disarms until the next pop.
  - A push clears the counter.
- Undefined: siwu_n tied to 1; no counter logic.

Test Plan:
- Push W=20'hABCDE, S=1 with txe_n=0, rxf_n=1 -> bytes 8'hD5, 8'h73, 8'h1E on three consecutive wr_n=0 edges; data_oe rises one cycle before wr_n; then IDLE, wr_n=1.
- Fill FIFO with 16 words -> word_ready=0, fifo_level=16. Further word_valid ignored. Drain yields 48 bytes back-to-back with no gaps.
- txe_n=1 for 5 cycles during byte1 of a word -> data_out holds byte1; idx unchanged; byte1 accepted once txe_n=0.
- rxf_n=0 asserted during byte1 of word 1 with 4 words queued -> word 1 completes, block goes IDLE with data_oe=0, and does not restart until rxf_n=1.
- rst asserted while idx=1 -> next cycle wr_n=1, data_oe=0, fifo_level=0.
- With FTDI_TX_SIWU_EN and FLUSH_IDLE=32: send one word, stay idle -> single siwu_n low pulse 32 cycles after return to IDLE; a push at cycle 20 suppresses it.
